branch_pc_unit: RTL and testbench
=================================

# branch_pc_unit

Program-counter and next-PC stage sitting directly downstream of the ALU in the single-cycle RV32I core. It consumes the ALU comparison flags (`less`, `zero`) together with the decoder's branch type and immediate, and resolves branches and jumps. It holds the architectural PC register and steps it by one instruction per enabled cycle. It also provides run/halt/trap sequencing and optional performance counters.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk`  input  1  core clock; all state updates on rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `en`  input  1  step enable; 0 = stall (PC holds).
- `halt`  input  1  level halt request.
- `branch`  input  3  branch type from decoder.
- `less`  input  1  ALU less flag.
- `zero`  input  1  ALU zero flag.
- `imm`  input  32  sign-extended immediate.
- `rs1`  input  32  register rs1 value (JALR base).
- `pc`  output  32  current PC (registered).
- `next_pc`  output  32  combinational PC for the next cycle.
- `taken`  output  1  combinational; control transfer this cycle.
- `trap`  output  1  registered; misaligned-target trap latched.
- `halted`  output  1  registered; state == HALT.
- `cycle_cnt`, `instret_cnt`, `br_taken_cnt`  output  32 each  performance counters.

## Operation
- Branch decode:
  - 000 none
  - 001 JAL
  - 010 JALR
  - 100 BEQ (taken if `zero`)
  - 101 BNE (`!zero`)
  - 110 BLT/BLTU (`less`)
  - 111 BGE/BGEU (`!less`)
  - 011 reserved: treated as none.
- Signed vs unsigned compare is selected upstream by `aluctr`. This block only reads `less`.
- Target computation (32-bit, wrap modulo 2^32, no overflow detection):
  - JAL / taken branch: `pc + imm`.
  - JALR: `(rs1 + imm) & ~32'h1`.
  - Otherwise: `pc + 4`.
- `next_pc` is the target when `taken`, else `pc + 4`.
- Misaligned: `taken` and `next_pc[1:0] != 2'b00`.
- State machine, 2-bit encoded, with states RUN, HALT, TRAP:
  - RUN, misaligned and `en`: go to TRAP. `pc` is NOT updated; `trap` is set.
  - RUN, else `halt`: go to HALT. `pc` holds.
  - RUN, else `en`: `pc <= next_pc`; stay in RUN.
  - RUN, else: hold (stall).
  - HALT: stay while `halt` = 1; go to RUN when `halt` = 0. `pc` holds in HALT.
  - TRAP: absorbing; only `rst` leaves it. `pc` holds the address of the faulting instruction.
- Priority within RUN is misaligned > halt > en.
- Misalignment is only evaluated when `en` = 1. With `en` = 0, a misaligned target does not trap.
- A retire event is a RUN-state cycle with `en` = 1 and no trap.

## Timing
- Reset (async, immediate) sets:
  - `pc` = `RESET_PC`
  - state = RUN
  - `trap` = 0, `halted` = 0
  - all counters = 0
- `taken` and `next_pc` are combinational from `pc`, `branch`, `less`, `zero`, `imm`, `rs1`. There are no registers in this path.
- `pc` changes one edge after a retiring cycle; branch penalty is zero cycles.
- `halted` and `trap` are asserted in the cycle after the transition edge.
- `halt` deasserted in HALT: RUN resumes and the first step occurs on the following edge where `en` = 1.
- `rst` asserted mid-operation from any state aborts it asynchronously. The first step after `rst` falls occurs on the first rising edge with `en` = 1.

## Configuration
- Macro `BRANCH_PC_PERF_CNT_EN`.
- Defined:
  - `cycle_cnt` increments every cycle out of reset, in all states.
  - `instret_cnt` increments on each retire event.
  - `br_taken_cnt` increments on each retire event with `taken` = 1.
  - All counters wrap from 32'hFFFF_FFFF to 0.
- Undefined: no counter registers are built. All three counter outputs are constant 0.

## Test plan
- Reset then sequential fetch: `RESET_PC` = 0, `en` = 1, `branch` = 000 for 3 cycles -> `pc` = 0, 4, 8, 12; `taken` = 0.
- Conditional branches at `pc` = 0x10, `imm` = 0x20:
  - BEQ with `zero` = 1 -> `pc` = 0x30.
  - BNE with `zero` = 1 -> `pc` = 0x14.
  - BGE with `less` = 0 -> taken.
- Jumps:
  - JALR with `rs1` = 0x101, `imm` = 0x4 -> `next_pc` = 0x104, no trap.
  - JAL with `imm` = 0xFFFF_FFF8 at `pc` = 0x8 -> `pc` = 0x0.
- Trap: JAL at `pc` = 0x40 with `imm` = 0x2, `en` = 1 -> `trap` = 1 next cycle, `pc` stays 0x40. The trap persists through `en`/`halt` toggles and clears only on `rst`.
- Halt/stall interaction:
  - `halt` = 1 at `pc` = 0x8 -> `halted` = 1 and `pc` holds.
  - Release `halt` -> `halted` = 0 and stepping resumes.
  - `en` = 0 -> `pc` holds, no trap even with a misaligned target.
- With `BRANCH_PC_PERF_CNT_EN` defined: 10 cycles out of reset with 6 retires, 2 of them taken -> `cycle_cnt` = 10, `instret_cnt` = 6, `br_taken_cnt` = 2. Asserting `rst` mid-run zeroes all three.

Source files
------------

// File: rtl/branch_pc_unit.sv
// PC register and next-PC resolution for the single-cycle RV32I core, with run/halt/trap sequencing.
// Optional performance counters are built when BRANCH_PC_PERF_CNT_EN is defined.
module branch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        halt,
    input  logic [2:0]  branch,
    input  logic        less,
    input  logic        zero,
    input  logic [31:0] imm,
    input  logic [31:0] rs1,
    output logic [31:0] pc,
    output logic [31:0] next_pc,
    output logic        taken,
    output logic        trap,
    output logic        halted,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt,
    output logic [31:0] br_taken_cnt
);

    localparam logic [1:0] RUN  = 2'd0;
    localparam logic [1:0] HALT = 2'd1;
    localparam logic [1:0] TRAP = 2'd2;

    localparam logic [2:0] BR_JAL  = 3'b001;
    localparam logic [2:0] BR_JALR = 3'b010;
    localparam logic [2:0] BR_BEQ  = 3'b100;
    localparam logic [2:0] BR_BNE  = 3'b101;
    localparam logic [2:0] BR_BLT  = 3'b110;
    localparam logic [2:0] BR_BGE  = 3'b111;

    logic [1:0]  state;
    logic [31:0] pc_plus4;
    logic [31:0] rel_target;
    logic [31:0] jalr_target;
    logic        misaligned;
    logic        retire;

    assign pc_plus4    = pc + 32'd4;
    assign rel_target  = pc + imm;
    assign jalr_target = (rs1 + imm) & ~32'h1;

    always_comb begin
        taken = 1'b0;
        case (branch)
            BR_JAL:  taken = 1'b1;
            BR_JALR: taken = 1'b1;
            BR_BEQ:  taken = zero;
            BR_BNE:  taken = !zero;
            BR_BLT:  taken = less;
            BR_BGE:  taken = !less;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        next_pc = pc_plus4;
        if (taken) begin
            next_pc = (branch == BR_JALR) ? jalr_target : rel_target;
        end
    end

    assign misaligned = taken && (next_pc[1:0] != 2'b00);
    assign retire     = (state == RUN) && en && !misaligned;

    // Misalignment only matters on an enabled cycle; a stalled bad target is harmless.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            pc    <= RESET_PC;
        end else begin
            case (state)
                RUN: begin
                    if (en && misaligned) begin
                        state <= TRAP;
                    end else if (halt) begin
                        state <= HALT;
                    end else if (en) begin
                        pc <= next_pc;
                    end
                end
                HALT: begin
                    if (!halt) begin
                        state <= RUN;
                    end
                end
                TRAP:    state <= TRAP;
                default: state <= RUN;
            endcase
        end
    end

    assign halted = (state == HALT);
    assign trap   = (state == TRAP);

`ifdef BRANCH_PC_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt    <= 32'd0;
            instret_cnt  <= 32'd0;
            br_taken_cnt <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (retire) begin
                instret_cnt <= instret_cnt + 32'd1;
                if (taken) begin
                    br_taken_cnt <= br_taken_cnt + 32'd1;
                end
            end
        end
    end
`else
    logic unused_retire;
    assign unused_retire = retire;
    assign cycle_cnt     = 32'd0;
    assign instret_cnt   = 32'd0;
    assign br_taken_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit: combinational vector table at a held PC plus
// hand-written sequences for stepping, halt, trap, reset and counters.
module tb_branch_pc_unit;

    logic        clk;
    logic        rst;
    logic        en;
    logic        halt;
    logic [2:0]  branch;
    logic        less;
    logic        zero;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        taken;
    logic        trap;
    logic        halted;
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;
    logic [31:0] br_taken_cnt;

    int n_cmp = 0;
    int n_err = 0;

    branch_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .en(en), .halt(halt), .branch(branch),
        .less(less), .zero(zero), .imm(imm), .rs1(rs1), .pc(pc),
        .next_pc(next_pc), .taken(taken), .trap(trap), .halted(halted),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt), .br_taken_cnt(br_taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  br;
        logic        lt;
        logic        zr;
        logic [31:0] im;
        logic [31:0] r1;
        logic        exp_taken;
        logic [31:0] exp_npc;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [2:0] b, input logic lt, input logic zr,
                         input logic [31:0] im, input logic [31:0] r1);
        en = e; branch = b; less = lt; zero = zr; imm = im; rs1 = r1; halt = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc();
        cyc();
        rst = 1'b0;
        #1;
    endtask

    // Jump to an aligned absolute address with JALR and step there.
    task automatic jump_to(input logic [31:0] addr);
        drive(1'b1, 3'b010, 1'b0, 1'b0, 32'h0, addr);
        cyc();
        check("jump_to_pc", pc, addr);
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0);

        vecs[0]  = '{3'b000, 1'b0, 1'b0, 32'h20, 32'h0, 1'b0, 32'h14};
        vecs[1]  = '{3'b011, 1'b1, 1'b1, 32'h20, 32'h0, 1'b0, 32'h14};
        vecs[2]  = '{3'b001, 1'b0, 1'b0, 32'h20, 32'h0, 1'b1, 32'h30};
        vecs[3]  = '{3'b001, 1'b0, 1'b0, 32'h2, 32'h0, 1'b1, 32'h12};
        vecs[4]  = '{3'b010, 1'b0, 1'b0, 32'h4, 32'h101, 1'b1, 32'h104};
        vecs[5]  = '{3'b010, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1000, 1'b1, 32'hFFE};
        vecs[6]  = '{3'b100, 1'b0, 1'b1, 32'h20, 32'h0, 1'b1, 32'h30};
        vecs[7]  = '{3'b100, 1'b0, 1'b0, 32'h20, 32'h0, 1'b0, 32'h14};
        vecs[8]  = '{3'b101, 1'b0, 1'b1, 32'h20, 32'h0, 1'b0, 32'h14};
        vecs[9]  = '{3'b101, 1'b0, 1'b0, 32'h20, 32'h0, 1'b1, 32'h30};
        vecs[10] = '{3'b110, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 32'h30};
        vecs[11] = '{3'b110, 1'b0, 1'b0, 32'h20, 32'h0, 1'b0, 32'h14};
        vecs[12] = '{3'b111, 1'b0, 1'b0, 32'h20, 32'h0, 1'b1, 32'h30};
        vecs[13] = '{3'b111, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h14};
        vecs[14] = '{3'b001, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0, 1'b1, 32'h0};
        vecs[15] = '{3'b010, 1'b0, 1'b0, 32'h8, 32'hFFFF_FFFC, 1'b1, 32'h4};

        // Reset state, including the async assertion before any edge.
        rst = 1'b1;
        #1;
        check("rst_async_pc", pc, 32'h0);
        do_reset();
        check("rst_pc", pc, 32'h0);
        check("rst_trap", {31'd0, trap}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_cycle_cnt", cycle_cnt, 32'd0);
        check("rst_instret_cnt", instret_cnt, 32'd0);
        check("rst_br_taken_cnt", br_taken_cnt, 32'd0);

        // Sequential fetch.
        drive(1'b1, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("seq_taken", {31'd0, taken}, 32'd0);
        check("seq_next_pc", next_pc, 32'h4);
        cyc();
        check("seq_pc_4", pc, 32'h4);
        cyc();
        check("seq_pc_8", pc, 32'h8);

        // Halt at pc 0x8, then release.
        halt = 1'b1;
        cyc();
        check("halt_halted", {31'd0, halted}, 32'd1);
        check("halt_pc", pc, 32'h8);
        cyc();
        check("halt_hold_halted", {31'd0, halted}, 32'd1);
        check("halt_hold_pc", pc, 32'h8);
        halt = 1'b0;
        cyc();
        check("resume_halted", {31'd0, halted}, 32'd0);
        check("resume_pc", pc, 32'h8);
        cyc();
        check("resume_step_pc", pc, 32'hC);
        cyc();
        check("resume_step_pc2", pc, 32'h10);

        // Combinational decode table at a stalled pc 0x10; no vector may trap or move pc.
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, vecs[i].br, vecs[i].lt, vecs[i].zr, vecs[i].im, vecs[i].r1);
            #1;
            check($sformatf("vec%0d_taken", i), {31'd0, taken}, {31'd0, vecs[i].exp_taken});
            check($sformatf("vec%0d_next_pc", i), next_pc, vecs[i].exp_npc);
            cyc();
            check($sformatf("vec%0d_stall_pc", i), pc, 32'h10);
            check($sformatf("vec%0d_no_trap", i), {31'd0, trap}, 32'd0);
        end

        // Conditional branches stepping from pc 0x10.
        drive(1'b1, 3'b100, 1'b0, 1'b1, 32'h20, 32'h0);
        cyc();
        check("beq_taken_pc", pc, 32'h30);
        jump_to(32'h10);
        drive(1'b1, 3'b101, 1'b0, 1'b1, 32'h20, 32'h0);
        cyc();
        check("bne_not_taken_pc", pc, 32'h14);
        jump_to(32'h10);
        drive(1'b1, 3'b111, 1'b0, 1'b0, 32'h20, 32'h0);
        #1;
        check("bge_taken", {31'd0, taken}, 32'd1);
        cyc();
        check("bge_pc", pc, 32'h30);

        // JALR clears bit 0 and does not trap.
        drive(1'b1, 3'b010, 1'b0, 1'b0, 32'h4, 32'h101);
        #1;
        check("jalr_next_pc", next_pc, 32'h104);
        cyc();
        check("jalr_pc", pc, 32'h104);
        check("jalr_no_trap", {31'd0, trap}, 32'd0);

        // JAL backwards with wrap.
        jump_to(32'h8);
        drive(1'b1, 3'b001, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0);
        cyc();
        check("jal_back_pc", pc, 32'h0);

        // Misaligned JAL traps and stays trapped.
        jump_to(32'h40);
        drive(1'b1, 3'b001, 1'b0, 1'b0, 32'h2, 32'h0);
        cyc();
        check("trap_set", {31'd0, trap}, 32'd1);
        check("trap_pc", pc, 32'h40);
        for (int i = 0; i < 4; i++) begin
            drive(i[0], 3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
            halt = i[1];
            cyc();
            check($sformatf("trap_sticky%0d", i), {31'd0, trap}, 32'd1);
            check($sformatf("trap_sticky_pc%0d", i), pc, 32'h40);
            check($sformatf("trap_not_halted%0d", i), {31'd0, halted}, 32'd0);
        end
        do_reset();
        check("trap_cleared", {31'd0, trap}, 32'd0);
        check("trap_rst_pc", pc, 32'h0);

`ifdef BRANCH_PC_PERF_CNT_EN
        // 10 cycles, 6 retires, 2 taken.
        do_reset();
        drive(1'b1, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0); cyc();
        drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0); cyc();
        drive(1'b1, 3'b001, 1'b0, 1'b0, 32'h8, 32'h0); cyc();
        drive(1'b1, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0); cyc();
        drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0); cyc();
        drive(1'b1, 3'b100, 1'b0, 1'b1, 32'h10, 32'h0); cyc();
        drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0); cyc();
        drive(1'b1, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0); cyc();
        drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0); cyc();
        drive(1'b1, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0); cyc();
        check("perf_pc", pc, 32'h28);
        check("perf_cycle_cnt", cycle_cnt, 32'd10);
        check("perf_instret_cnt", instret_cnt, 32'd6);
        check("perf_br_taken_cnt", br_taken_cnt, 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("perf_rst_cycle_cnt", cycle_cnt, 32'd0);
        check("perf_rst_instret_cnt", instret_cnt, 32'd0);
        check("perf_rst_br_taken_cnt", br_taken_cnt, 32'd0);
        rst = 1'b0;
`else
        // Without the counters every output stays zero even while retiring.
        drive(1'b1, 3'b001, 1'b0, 1'b0, 32'h8, 32'h0);
        cyc();
        cyc();
        check("nocnt_pc", pc, 32'h10);
        check("nocnt_cycle_cnt", cycle_cnt, 32'd0);
        check("nocnt_instret_cnt", instret_cnt, 32'd0);
        check("nocnt_br_taken_cnt", br_taken_cnt, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
